// File: rtl/approx_mul_rr_sched.sv
// -----------------------------------------------------------------------------
// approx_mul_rr_sched
//
// Round-robin scheduler that time-shares one external combinational 8x8
// approximate multiplier among NREQ requesters. There are two register stages
// around the multiplier:
//   stage 1 : operand registers (mul_in1/mul_in2) plus requester tag
//   stage 2 : product register (rsp_prod) plus tag, valid/ready handshake out
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (synchronous release)
//   req_valid  in   [NREQ]      per-requester request valid
//   req_ready  out  [NREQ]      per-requester accept, one-hot or zero
//   req_a      in   [NREQ*AW]   operand A, requester i at [i*AW +: AW]
//   req_b      in   [NREQ*AW]   operand B, same packing
//   mul_in1    out  [AW]        registered operand A to multiplier IN1
//   mul_in2    out  [AW]        registered operand B to multiplier IN2
//   mul_out    in   [2*AW]      multiplier result (combinational)
//   rsp_valid  out              response valid
//   rsp_ready  in               consumer ready
//   rsp_id     out  [IDW]       requester that issued the request
//   rsp_prod   out  [2*AW]      registered multiplier result
//
// Optional feature, macro APPROX_MUL_ERRSTAT_EN, adds:
//   err_clr    in               synchronous clear of both statistics
//   err_cnt    out  [16]        saturating count of inexact responses
//   err_sum    out  [24]        saturating sum of |rsp_prod - exact|
// -----------------------------------------------------------------------------
module approx_mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int AW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_a,
    input  logic [NREQ*AW-1:0]   req_b,
    output logic [AW-1:0]        mul_in1,
    output logic [AW-1:0]        mul_in2,
    input  logic [2*AW-1:0]      mul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*AW-1:0]      rsp_prod
`ifdef APPROX_MUL_ERRSTAT_EN
    ,
    input  logic                 err_clr,
    output logic [15:0]          err_cnt,
    output logic [23:0]          err_sum
`endif
);

    logic [IDW-1:0]  rr_ptr_reg;
    logic            s1_vld_reg;
    logic [IDW-1:0]  s1_id_reg;
    logic [AW-1:0]   mul_in1_reg;
    logic [AW-1:0]   mul_in2_reg;
    logic            rsp_valid_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [2*AW-1:0] rsp_prod_reg;

    logic            adv;
    logic            load;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  rr_ptr_next;
    logic [AW-1:0]   a_arr [NREQ];
    logic [AW-1:0]   b_arr [NREQ];

    // Stage 2 frees when empty or draining; stage 1 follows it in lock-step.
    // Nothing is accepted while reset is asserted.
    assign adv  = !rsp_valid_reg || rsp_ready;
    assign load = adv && rst_n;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*AW +: AW];
            assign b_arr[gi]     = req_b[gi*AW +: AW];
            assign req_ready[gi] = load && grant_vld && (grant_idx == IDW'(gi));
        end
    endgenerate

    // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int p;
        grant_vld = 1'b0;
        grant_idx = '0;
        p         = 0;
        if (load) begin
            for (int k = 0; k < NREQ; k++) begin
                p = int'(rr_ptr_reg) + k;
                if (p >= NREQ) begin
                    p = p - NREQ;
                end
                if (!grant_vld && req_valid[IDW'(p)]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(p);
                end
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            s1_vld_reg    <= 1'b0;
            s1_id_reg     <= '0;
            mul_in1_reg   <= '0;
            mul_in2_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_prod_reg  <= '0;
        end else if (adv) begin
            if (grant_vld) begin
                mul_in1_reg <= a_arr[grant_idx];
                mul_in2_reg <= b_arr[grant_idx];
                s1_id_reg   <= grant_idx;
                s1_vld_reg  <= 1'b1;
                rr_ptr_reg  <= rr_ptr_next;
            end else begin
                // Operands hold so the multiplier inputs do not toggle.
                s1_vld_reg  <= 1'b0;
            end
            rsp_valid_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                rsp_prod_reg <= mul_out;
                rsp_id_reg   <= s1_id_reg;
            end
        end
    end

    assign mul_in1   = mul_in1_reg;
    assign mul_in2   = mul_in2_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_prod  = rsp_prod_reg;

`ifdef APPROX_MUL_ERRSTAT_EN
    logic [2*AW-1:0] exact_s1;
    logic [2*AW-1:0] exact_reg;
    logic [2*AW-1:0] err_diff;
    logic [24:0]     sum_ext;
    logic [15:0]     err_cnt_reg;
    logic [23:0]     err_sum_reg;

    assign exact_s1 = (2*AW)'(mul_in1_reg) * (2*AW)'(mul_in2_reg);
    assign err_diff = (rsp_prod_reg >= exact_reg) ? (rsp_prod_reg - exact_reg)
                                                  : (exact_reg - rsp_prod_reg);
    assign sum_ext  = {1'b0, err_sum_reg} + 25'(err_diff);

    // Exact product travels alongside rsp_prod so both describe one response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_reg <= '0;
        end else if (adv && s1_vld_reg) begin
            exact_reg <= exact_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
            err_sum_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= '0;
            err_sum_reg <= '0;
        end else if (rsp_valid_reg && rsp_ready) begin
            if ((err_diff != '0) && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            err_sum_reg <= sum_ext[24] ? 24'hFF_FFFF : sum_ext[23:0];
        end
    end

    assign err_cnt = err_cnt_reg;
    assign err_sum = err_sum_reg;
`endif

endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_approx_mul_rr_sched
//
// Bench for approx_mul_rr_sched. A behavioural approximate multiplier model
// stands in for the external netlist and drives mul_out. Each accepted
// request pushes {id, expected product} to a scoreboard queue; responses are
// popped and compared on handshake. A grant table covers round-robin order
// and skip fairness; hand-written sequences cover backpressure, throughput,
// mid-stream reset and (when enabled) the error statistics.
// -----------------------------------------------------------------------------
module tb_approx_mul_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int AW   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  mul_in1;
    logic [7:0]  mul_in2;
    logic [15:0] mul_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
`ifdef APPROX_MUL_ERRSTAT_EN
    logic        err_clr;
    logic [15:0] err_cnt;
    logic [23:0] err_sum;
`endif

    always #5 clk = ~clk;

    // Stand-in approximate multiplier: exact product with a deterministic
    // error pattern in the middle bits.
    function automatic logic [15:0] approx_model(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return p ^ {8'h00, a[3:0] & b[3:0], 4'h0};
    endfunction

    assign mul_out = approx_model(mul_in1, mul_in2);

    approx_mul_rr_sched #(.NREQ(NREQ), .IDW(IDW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
`ifdef APPROX_MUL_ERRSTAT_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .err_sum   (err_sum)
`endif
    );

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_rdy;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rsp = 0;
    int   m_ptr = 0;
    logic m_s1  = 1'b0;
    logic m_s2  = 1'b0;
    logic fix_ops = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 2 time units later, then
    // update the occupancy/pointer model for the upcoming rising edge.
    task automatic drive_cycle(input logic [3:0] v, input logic rr, output logic [3:0] rdy_seen);
        logic       load;
        logic       gv;
        int         g;
        int         idx;
        logic [3:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = fix_ops ? 8'hFF : 8'($urandom);
            req_b[i*8 +: 8] = fix_ops ? 8'hFF : 8'($urandom);
        end
        #2;
        rdy_seen = req_ready;
        load = !m_s2 || rr;
        gv   = 1'b0;
        g    = 0;
        if (load) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!gv && v[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
        exp_rdy = gv ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
        if (m_s2 && sb.size() > 0) begin
            chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            chk("rsp_prod", 32'(rsp_prod), 32'(sb[0].prod));
            if (rr) begin
                $display("rsp id=%0d prod=%04h", rsp_id, rsp_prod);
                void'(sb.pop_front());
                n_rsp++;
            end
        end
        if (gv) begin
            e.id   = 2'(g);
            e.prod = approx_model(req_a[g*8 +: 8], req_b[g*8 +: 8]);
            sb.push_back(e);
            m_ptr = (g + 1) % 4;
        end
        if (load) begin
            m_s2 = m_s1;
            m_s1 = gv;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[12];
        logic [3:0] rdy;
`ifdef APPROX_MUL_ERRSTAT_EN
        logic [15:0] ap;
        logic [15:0] ex;
        logic [15:0] df;
`endif
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};  // wrap back to 0, ptr -> 1
        tbl[5]  = '{4'b0010, 4'b0010};  // ptr -> 2
        tbl[6]  = '{4'b1001, 4'b1000};  // skip 2, grant 3
        tbl[7]  = '{4'b1001, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b1000};  // requester 1..2 not valid, 3 again
        tbl[9]  = '{4'b0000, 4'b0000};  // idle keeps ptr at 0
        tbl[10] = '{4'b0110, 4'b0010};
        tbl[11] = '{4'b0000, 4'b0000};

`ifdef APPROX_MUL_ERRSTAT_EN
        err_clr = 1'b0;
`endif
        // Reset state, with requests already asserted.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = $urandom;
        req_b     = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_mul_in1", 32'(mul_in1), 32'd0);
        chk("reset_mul_in2", 32'(mul_in2), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_prod", 32'(rsp_prod), 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        // Round-robin order and skip fairness.
        for (int i = 0; i < 12; i++) begin
            drive_cycle(tbl[i].valid, 1'b1, rdy);
            chk($sformatf("grant_tbl[%0d]", i), 32'(rdy), 32'(tbl[i].exp_rdy));
        end
        repeat (2) drive_cycle(4'b0000, 1'b1, rdy);
        chk("rr_drain_empty", 32'(sb.size()), 32'd0);

        // Backpressure: stall 5 cycles with all requesters active.
        drive_cycle(4'b1111, 1'b1, rdy);
        drive_cycle(4'b1111, 1'b1, rdy);
        repeat (5) drive_cycle(4'b1111, 1'b0, rdy);
        chk("bp_stalled_ready", 32'(rdy), 32'd0);
        repeat (4) drive_cycle(4'b1111, 1'b1, rdy);
        repeat (3) drive_cycle(4'b0000, 1'b1, rdy);
        chk("bp_drain_empty", 32'(sb.size()), 32'd0);

        // Throughput: 100 random requests back to back.
        n_rsp = 0;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(4'($urandom_range(1, 15)), 1'b1, rdy);
        end
        repeat (2) drive_cycle(4'b0000, 1'b1, rdy);
        chk("tput_rsp_count", 32'(n_rsp), 32'd100);
        chk("tput_drain_empty", 32'(sb.size()), 32'd0);

        // Mid-stream reset with two entries in flight.
        drive_cycle(4'b1111, 1'b1, rdy);
        drive_cycle(4'b1111, 1'b1, rdy);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        repeat (3) drive_cycle(4'b0000, 1'b1, rdy);
        drive_cycle(4'b1111, 1'b1, rdy);
        chk("post_reset_grant", 32'(rdy), 32'b0001);
        repeat (2) drive_cycle(4'b0000, 1'b1, rdy);
        chk("post_reset_empty", 32'(sb.size()), 32'd0);

`ifdef APPROX_MUL_ERRSTAT_EN
        fix_ops = 1'b1;
        err_clr = 1'b1;
        drive_cycle(4'b0000, 1'b1, rdy);
        err_clr = 1'b0;
        repeat (3) drive_cycle(4'b0001, 1'b1, rdy);
        repeat (3) drive_cycle(4'b0000, 1'b1, rdy);
        ap = approx_model(8'hFF, 8'hFF);
        ex = 16'd65025;
        df = (ap >= ex) ? (ap - ex) : (ex - ap);
        chk("err_cnt", 32'(err_cnt), (df != 16'd0) ? 32'd3 : 32'd0);
        chk("err_sum", 32'(err_sum), 32'd3 * 32'(df));
        err_clr = 1'b1;
        drive_cycle(4'b0000, 1'b1, rdy);
        err_clr = 1'b0;
        #1;
        chk("err_cnt_clr", 32'(err_cnt), 32'd0);
        chk("err_sum_clr", 32'(err_sum), 32'd0);
        fix_ops = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
